skinny_round_ctrl: RTL and testbench

//  Sequencer for the serial SKINNY-128-384 encryption datapath.
//  - Accepts a 16-cycle byte-serial load: 8-bit plaintext and 24-bit tweakey slices per cycle.
//  - Steps the round datapath for ROUNDS rounds and generates the 6-bit LFSR round constant.
//  - Strobes the 16 ciphertext bytes out, then raises done.

---
 rtl/skinny_round_ctrl.sv | 142 ++++++++++++++
 tb/tb_skinny_round_ctrl.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/skinny_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : skinny_round_ctrl
// Purpose  : Load / round / unload sequencer for the serial SKINNY-128-384
//            datapath, including the 6-bit LFSR round constant.
// Revision : 1.0 - initial release
// ============================================================================
module skinny_round_ctrl #(
  parameter int NUM_BYTES = 16,
  parameter int ROUNDS    = 56
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  output logic                         load_en,
  output logic [$clog2(NUM_BYTES)-1:0] load_idx,
  output logic                         round_en,
  output logic [$clog2(ROUNDS)-1:0]    round_idx,
  output logic [5:0]                   rc,
  output logic                         unload_en,
  output logic [$clog2(NUM_BYTES)-1:0] unload_idx,
  output logic                         busy,
  output logic                         done
);

  localparam int C_BYTE_W = $clog2(NUM_BYTES);
  localparam int C_CNT_W  = $clog2(ROUNDS);

  localparam logic [C_CNT_W-1:0] C_LAST_BYTE  = C_CNT_W'(NUM_BYTES - 1);
  localparam logic [C_CNT_W-1:0] C_LAST_ROUND = C_CNT_W'(ROUNDS - 1);
  localparam logic [C_CNT_W-1:0] C_CNT_ONE    = C_CNT_W'(1);

  // The done phase has no cycle of its own: the final unload beat lands in
  // IDLE with the done level set, so a start that same cycle is accepted.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_RUN    = 2'd2,
    S_UNLOAD = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [C_CNT_W-1:0]   r_cnt;
  logic [C_CNT_W-1:0]   w_cnt_next;
  logic [5:0]           r_lfsr;
  logic [5:0]           w_lfsr_next;
  logic [5:0]           w_lfsr_step;
  logic                 r_done;
  logic                 w_done_next;

  assign w_lfsr_step = {r_lfsr[4:0], r_lfsr[5] ^ r_lfsr[4] ^ 1'b1};

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_lfsr  <= 6'h00;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_lfsr  <= w_lfsr_next;
      r_done  <= w_done_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_lfsr_next  = r_lfsr;
    w_done_next  = r_done;
    load_en      = 1'b0;
    load_idx     = '0;
    round_en     = 1'b0;
    round_idx    = '0;
    rc           = 6'h00;
    unload_en    = 1'b0;
    unload_idx   = '0;

    case (r_state)
      S_IDLE: begin
        // Byte 0 is captured in the start cycle itself.
        load_en = start;
        if (start) begin
          w_cnt_next   = C_CNT_ONE;
          w_state_next = S_LOAD;
          w_done_next  = 1'b0;
        end
      end

      S_LOAD: begin
        load_en  = 1'b1;
        load_idx = r_cnt[C_BYTE_W-1:0];
        if (r_cnt == C_LAST_BYTE) begin
          w_cnt_next   = '0;
          w_state_next = S_RUN;
        end else begin
          w_cnt_next = r_cnt + C_CNT_ONE;
        end
      end

      S_RUN: begin
        // rc is the post-update LFSR value, so round 0 sees 6'h01.
        round_en    = 1'b1;
        round_idx   = r_cnt;
        rc          = w_lfsr_step;
        w_lfsr_next = w_lfsr_step;
        if (r_cnt == C_LAST_ROUND) begin
          w_cnt_next   = '0;
          w_lfsr_next  = 6'h00;
          w_state_next = S_UNLOAD;
        end else begin
          w_cnt_next = r_cnt + C_CNT_ONE;
        end
      end

      S_UNLOAD: begin
        unload_en  = 1'b1;
        unload_idx = r_cnt[C_BYTE_W-1:0];
        if (r_cnt == C_LAST_BYTE) begin
          w_cnt_next   = '0;
          w_done_next  = 1'b1;
          w_state_next = S_IDLE;
        end else begin
          w_cnt_next = r_cnt + C_CNT_ONE;
        end
      end

      default: begin
        w_cnt_next   = '0;
        w_lfsr_next  = 6'h00;
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign busy = (r_state != S_IDLE);
  assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_skinny_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_skinny_round_ctrl
// Purpose  : Directed cycle-by-cycle bench for skinny_round_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_skinny_round_ctrl;

  logic       clock;
  logic       reset;
  logic       start;
  logic       load_en;
  logic [3:0] load_idx;
  logic       round_en;
  logic [5:0] round_idx;
  logic [5:0] rc;
  logic       unload_en;
  logic [3:0] unload_idx;
  logic       busy;
  logic       done;

  int n_checks;
  int n_pass;

  // SKINNY-128-384 round constants, rounds 0..55.
  logic [5:0] rc_tbl [56];

  skinny_round_ctrl #(
    .NUM_BYTES (16),
    .ROUNDS    (56)
  ) u_dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .load_en    (load_en),
    .load_idx   (load_idx),
    .round_en   (round_en),
    .round_idx  (round_idx),
    .rc         (rc),
    .unload_en  (unload_en),
    .unload_idx (unload_idx),
    .busy       (busy),
    .done       (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic check_quiet(input string tag, input logic exp_done);
    check({tag, " load_en"},   32'(load_en),   32'd0);
    check({tag, " round_en"},  32'(round_en),  32'd0);
    check({tag, " unload_en"}, 32'(unload_en), 32'd0);
    check({tag, " idx"},       32'({load_idx, round_idx, rc, unload_idx}), 32'd0);
    check({tag, " busy"},      32'(busy),      32'd0);
    check({tag, " done"},      32'(done),      32'(exp_done));
  endtask

  // Walks one block from its start cycle (c=0) through the last unload
  // beat (c=87). Optionally asserts reset during cycle abort_at.
  task automatic run_block(input int hold, input int poke, input logic done_before,
                           input int abort_at);
    bit aborted = 1'b0;
    for (int c = 0; c < 88 && !aborted; c++) begin
      bit in_load, in_run, in_unl;
      @(negedge clock);
      start = (c < hold) || (c == poke);
      #1;
      in_load = (c < 16);
      in_run  = (c >= 16) && (c < 72);
      in_unl  = (c >= 72);
      check("load_en",    32'(load_en),    32'(in_load));
      check("load_idx",   32'(load_idx),   in_load ? 32'(c) : 32'd0);
      check("round_en",   32'(round_en),   32'(in_run));
      check("round_idx",  32'(round_idx),  in_run ? 32'(c - 16) : 32'd0);
      check("rc",         32'(rc),         in_run ? 32'(rc_tbl[c - 16]) : 32'd0);
      check("unload_en",  32'(unload_en),  32'(in_unl));
      check("unload_idx", 32'(unload_idx), in_unl ? 32'(c - 72) : 32'd0);
      check("busy",       32'(busy),       32'(c > 0));
      check("done",       32'(done),       (c == 0) ? 32'(done_before) : 32'd0);
      if (c == abort_at) begin
        reset   = 1'b1;
        aborted = 1'b1;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    rc_tbl = '{6'h01, 6'h03, 6'h07, 6'h0F, 6'h1F, 6'h3E, 6'h3D, 6'h3B,
               6'h37, 6'h2F, 6'h1E, 6'h3C, 6'h39, 6'h33, 6'h27, 6'h0E,
               6'h1D, 6'h3A, 6'h35, 6'h2B, 6'h16, 6'h2C, 6'h18, 6'h30,
               6'h21, 6'h02, 6'h05, 6'h0B, 6'h17, 6'h2E, 6'h1C, 6'h38,
               6'h31, 6'h23, 6'h06, 6'h0D, 6'h1B, 6'h36, 6'h2D, 6'h1A,
               6'h34, 6'h29, 6'h12, 6'h24, 6'h08, 6'h11, 6'h22, 6'h04,
               6'h09, 6'h13, 6'h26, 6'h0C, 6'h19, 6'h32, 6'h25, 6'h0A};
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b1;
    start    = 1'b0;

    // Reset held for 10 cycles.
    repeat (10) @(negedge clock);
    #1;
    check_quiet("reset", 1'b0);
    @(negedge clock);
    reset = 1'b0;

    // Start held 17 cycles: the extra high cycle lands in RUN and is ignored.
    run_block(17, -1, 1'b0, -1);
    @(negedge clock);
    #1;
    check_quiet("done1", 1'b1);

    // Single-cycle start; a second start mid-run must not reload.
    run_block(1, 40, 1'b1, -1);
    @(negedge clock);
    #1;
    check_quiet("done2", 1'b1);

    // Reset at round_idx 20 discards the block and clears done.
    run_block(1, -1, 1'b1, 36);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check_quiet("abort", 1'b0);

    // Fresh block after the abort restarts rc at 0x01, then back-to-back
    // start in the cycle done rises.
    run_block(1, -1, 1'b0, -1);
    run_block(1, -1, 1'b1, -1);
    @(negedge clock);
    #1;
    check_quiet("done3", 1'b1);

    repeat (2) @(negedge clock);
    #1;
    check_quiet("idle", 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
